ifetch_icache: RTL and testbench

Instruction fetch unit with a direct-mapped instruction cache. It is the requester on the instruction-fetch port of the memory controller. It sequences the PC and serves hits in one cycle. On a miss it holds a fetch request to the memory controller until the done pulse arrives, then fills the cache. It delivers one instruction per cycle to the issue stage and accepts jump redirects at any time, including while a miss is outstanding.

---
 rtl/ifetch_icache.sv | 206 ++++++++++++++++++++
 tb/tb_ifetch_icache.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_icache.sv
// ifetch_icache
// Instruction fetch unit with a direct-mapped instruction cache.
// Sequences the PC, serves cache hits in one cycle, and on a miss holds a
// fetch request to the memory controller until the done pulse, then fills
// the cache. Jump redirects are accepted at any time, including while a
// miss is outstanding; a redirected-away fill still lands in the cache but
// is never emitted.
//
// Ports:
//   clk          - single clock, all state updates on rising edge
//   rst_n        - synchronous active-low reset
//   rdy          - global enable; 0 freezes every register
//   oMEM_en      - fetch request, held high until iMEM_done
//   oMEM_addr    - request word address, stable while oMEM_en=1
//   iMEM_done    - one-cycle completion pulse, iMEM_inst valid with it
//   iMEM_inst    - fetched instruction word
//   iISSUE_full  - issue stage cannot accept an instruction
//   iJUMP_en     - redirect pulse
//   iJUMP_pc     - redirect target (bits [1:0] forced to 0)
//   oINST_valid  - registered instruction-valid strobe
//   oINST        - instruction word
//   oINST_pc     - PC of oINST
module ifetch_icache #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          IDX_W    = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  output logic        oMEM_en,
  output logic [31:0] oMEM_addr,
  input  logic        iMEM_done,
  input  logic [31:0] iMEM_inst,
  input  logic        iISSUE_full,
  input  logic        iJUMP_en,
  input  logic [31:0] iJUMP_pc,
  output logic        oINST_valid,
  output logic [31:0] oINST,
  output logic [31:0] oINST_pc
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 30 - IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MISS    = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  // Registered state and next-state values
  state_e             state_q,      state_d;
  logic [31:0]        pc_q,         pc_d;
  logic [31:0]        req_addr_q,   req_addr_d;
  logic               mem_en_q,     mem_en_d;
  logic               inst_valid_q, inst_valid_d;
  logic [31:0]        inst_q,       inst_d;
  logic [31:0]        inst_pc_q,    inst_pc_d;
  logic [ENTRIES-1:0] valid_q,      valid_d;

  // Cache storage; tag/data need no reset because valid_q gates their use
  logic [TAG_W-1:0]   tag_q  [ENTRIES];
  logic [31:0]        data_q [ENTRIES];

  // Lookup and fill helpers
  logic [IDX_W-1:0]   lkp_idx_s;
  logic [TAG_W-1:0]   lkp_tag_s;
  logic               hit_s;
  logic [IDX_W-1:0]   fill_idx_s;
  logic [TAG_W-1:0]   fill_tag_s;
  logic               fill_en_s;
  logic [31:0]        jump_tgt_s;

  assign lkp_idx_s  = pc_q[IDX_W+1:2];
  assign lkp_tag_s  = pc_q[31:IDX_W+2];
  assign hit_s      = valid_q[lkp_idx_s] && (tag_q[lkp_idx_s] == lkp_tag_s);
  assign fill_idx_s = req_addr_q[IDX_W+1:2];
  assign fill_tag_s = req_addr_q[31:IDX_W+2];
  assign jump_tgt_s = iJUMP_pc & 32'hFFFF_FFFC;

  assign oMEM_en     = mem_en_q;
  assign oMEM_addr   = req_addr_q;
  assign oINST_valid = inst_valid_q;
  assign oINST       = inst_q;
  assign oINST_pc    = inst_pc_q;

  // Next-state and output computation for the fetch FSM
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    mem_en_d     = mem_en_q;
    inst_valid_d = 1'b0;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    valid_d      = valid_q;
    fill_en_s    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (iJUMP_en) begin
          pc_d = jump_tgt_s;
        end else if (hit_s && !iISSUE_full) begin
          inst_valid_d = 1'b1;
          inst_d       = data_q[lkp_idx_s];
          inst_pc_d    = pc_q;
          pc_d         = pc_q + 32'd4;
        end else if (hit_s) begin
          pc_d = pc_q;
        end else begin
          req_addr_d = pc_q;
          mem_en_d   = 1'b1;
          state_d    = ST_MISS;
        end
      end

      ST_MISS: begin
        if (iMEM_done) begin
          fill_en_s           = 1'b1;
          valid_d[fill_idx_s] = 1'b1;
          mem_en_d            = 1'b0;
          state_d             = ST_IDLE;
          if (iJUMP_en) begin
            pc_d = jump_tgt_s;
          end else if (!iISSUE_full) begin
            inst_valid_d = 1'b1;
            inst_d       = iMEM_inst;
            inst_pc_d    = req_addr_q;
            pc_d         = req_addr_q + 32'd4;
          end else begin
            // pc still equals req_addr, so the next IDLE cycle hits
            pc_d = pc_q;
          end
        end else if (iJUMP_en) begin
          // The request must stay up until done; its result is dropped
          pc_d    = jump_tgt_s;
          state_d = ST_DISCARD;
        end else begin
          state_d = ST_MISS;
        end
      end

      ST_DISCARD: begin
        if (iJUMP_en) begin
          pc_d = jump_tgt_s;
        end else begin
          pc_d = pc_q;
        end
        if (iMEM_done) begin
          fill_en_s           = 1'b1;
          valid_d[fill_idx_s] = 1'b1;
          mem_en_d            = 1'b0;
          state_d             = ST_IDLE;
        end else begin
          state_d = ST_DISCARD;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        mem_en_d = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset and rdy-gated update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      req_addr_q   <= 32'h0;
      mem_en_q     <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= 32'h0;
      inst_pc_q    <= 32'h0;
      valid_q      <= '0;
    end else if (rdy) begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      mem_en_q     <= mem_en_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      valid_q      <= valid_d;
    end else begin
      state_q      <= state_q;
      pc_q         <= pc_q;
      req_addr_q   <= req_addr_q;
      mem_en_q     <= mem_en_q;
      inst_valid_q <= inst_valid_q;
      inst_q       <= inst_q;
      inst_pc_q    <= inst_pc_q;
      valid_q      <= valid_q;
    end
  end

  // Cache tag/data write on fill completion
  always_ff @(posedge clk) begin
    if (rst_n && rdy && fill_en_s) begin
      tag_q[fill_idx_s]  <= fill_tag_s;
      data_q[fill_idx_s] <= iMEM_inst;
    end
  end

endmodule

// File: tb/tb_ifetch_icache.sv
module tb_ifetch_icache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        oMEM_en;
  logic [31:0] oMEM_addr;
  logic        iMEM_done;
  logic [31:0] iMEM_inst;
  logic        iISSUE_full;
  logic        iJUMP_en;
  logic [31:0] iJUMP_pc;
  logic        oINST_valid;
  logic [31:0] oINST;
  logic [31:0] oINST_pc;

  int errors = 0;
  int checks = 0;
  int cnt    = 0;

  ifetch_icache #(.RESET_PC(32'h0), .IDX_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rdy         (rdy),
    .oMEM_en     (oMEM_en),
    .oMEM_addr   (oMEM_addr),
    .iMEM_done   (iMEM_done),
    .iMEM_inst   (iMEM_inst),
    .iISSUE_full (iISSUE_full),
    .iJUMP_en    (iJUMP_en),
    .iJUMP_pc    (iJUMP_pc),
    .oINST_valid (oINST_valid),
    .oINST       (oINST),
    .oINST_pc    (oINST_pc)
  );

  always #5 clk = ~clk;

  // Program memory contents seen by the memory controller model
  function automatic logic [31:0] memword(input logic [31:0] a);
    case (a)
      32'h0:   memword = 32'h00500093;
      32'h4:   memword = 32'h00100113;
      default: memword = 32'hC0DE_0000 | {16'h0, a[15:0]};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; then the controller model: done in the 5th cycle of a request
  task automatic tick();
    logic en_b;
    logic rdy_b;
    en_b  = oMEM_en;
    rdy_b = rdy;
    @(posedge clk);
    #1;
    if (oMEM_en !== 1'b1) cnt = 0;
    else if (en_b === 1'b1 && rdy_b) cnt = cnt + 1;
    iMEM_done = (oMEM_en === 1'b1) && (cnt == 4);
    iMEM_inst = iMEM_done ? memword(oMEM_addr) : 32'h0;
  endtask

  task automatic expect_miss(input logic [31:0] a);
    tick();
    chk("miss_en_rise", {31'h0, oMEM_en}, 32'h1);
    chk("miss_addr", oMEM_addr, a);
    chk("miss_no_valid", {31'h0, oINST_valid}, 32'h0);
    repeat (4) tick();
    chk("miss_en_held", {31'h0, oMEM_en}, 32'h1);
    chk("miss_addr_held", oMEM_addr, a);
    tick();
    chk("fill_valid", {31'h0, oINST_valid}, 32'h1);
    chk("fill_inst", oINST, memword(a));
    chk("fill_pc", oINST_pc, a);
    chk("fill_en_fall", {31'h0, oMEM_en}, 32'h0);
  endtask

  task automatic expect_hit(input logic [31:0] a);
    tick();
    chk("hit_valid", {31'h0, oINST_valid}, 32'h1);
    chk("hit_inst", oINST, memword(a));
    chk("hit_pc", oINST_pc, a);
    chk("hit_no_req", {31'h0, oMEM_en}, 32'h0);
  endtask

  task automatic do_jump(input logic [31:0] t);
    iJUMP_en = 1'b1;
    iJUMP_pc = t;
    tick();
    iJUMP_en = 1'b0;
    chk("jump_no_emit", {31'h0, oINST_valid}, 32'h0);
    chk("jump_no_req", {31'h0, oMEM_en}, 32'h0);
  endtask

  initial begin
    rst_n       = 1'b0;
    rdy         = 1'b1;
    iMEM_done   = 1'b0;
    iMEM_inst   = 32'h0;
    iISSUE_full = 1'b0;
    iJUMP_en    = 1'b0;
    iJUMP_pc    = 32'h0;

    // Reset state
    tick();
    tick();
    chk("rst_en", {31'h0, oMEM_en}, 32'h0);
    chk("rst_addr", oMEM_addr, 32'h0);
    chk("rst_valid", {31'h0, oINST_valid}, 32'h0);
    chk("rst_inst", oINST, 32'h0);
    chk("rst_pc", oINST_pc, 32'h0);
    rst_n = 1'b1;

    // Cold misses at 0 and 4
    expect_miss(32'h0);
    expect_miss(32'h4);

    // Re-run both from the cache: two consecutive hits, no request
    do_jump(32'h0);
    expect_hit(32'h0);
    expect_hit(32'h4);

    // Redirect two cycles into the miss at 8; low address bits ignored
    tick();
    chk("m8_en", {31'h0, oMEM_en}, 32'h1);
    chk("m8_addr", oMEM_addr, 32'h8);
    tick();
    iJUMP_en = 1'b1;
    iJUMP_pc = 32'h103;
    tick();
    iJUMP_en = 1'b0;
    chk("disc_en", {31'h0, oMEM_en}, 32'h1);
    chk("disc_addr", oMEM_addr, 32'h8);
    chk("disc_no_emit", {31'h0, oINST_valid}, 32'h0);
    tick();
    tick();
    chk("disc_addr_at_done", oMEM_addr, 32'h8);
    chk("disc_done_seen", {31'h0, iMEM_done}, 32'h1);
    tick();
    chk("disc_no_emit_pc8", {31'h0, oINST_valid}, 32'h0);
    chk("disc_en_fall", {31'h0, oMEM_en}, 32'h0);
    expect_miss(32'h100);

    // Issue full while the fill of 0x104 completes
    tick();
    chk("m104_en", {31'h0, oMEM_en}, 32'h1);
    chk("m104_addr", oMEM_addr, 32'h104);
    iISSUE_full = 1'b1;
    repeat (4) tick();
    tick();
    chk("full_no_emit", {31'h0, oINST_valid}, 32'h0);
    chk("full_en_fall", {31'h0, oMEM_en}, 32'h0);
    tick();
    chk("full_hold", {31'h0, oINST_valid}, 32'h0);
    chk("full_no_req", {31'h0, oMEM_en}, 32'h0);
    iISSUE_full = 1'b0;
    expect_hit(32'h104);

    // Entry 2 was filled by the discarded request
    do_jump(32'h8);
    expect_hit(32'h8);

    // 0x0 and 0x100 share index 0: each access refills
    do_jump(32'h0);
    expect_miss(32'h0);
    do_jump(32'h100);
    expect_miss(32'h100);
    do_jump(32'h0);
    expect_miss(32'h0);

    // rdy low for 3 cycles mid-miss at 4 (index 1 holds tag of 0x104)
    tick();
    chk("m4_en", {31'h0, oMEM_en}, 32'h1);
    chk("m4_addr", oMEM_addr, 32'h4);
    tick();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_en", {31'h0, oMEM_en}, 32'h1);
      chk("frz_addr", oMEM_addr, 32'h4);
      chk("frz_valid", {31'h0, oINST_valid}, 32'h0);
      chk("frz_inst", oINST, 32'h00500093);
      chk("frz_pc", oINST_pc, 32'h0);
    end
    rdy = 1'b1;
    tick();
    tick();
    chk("pre_rst_en", {31'h0, oMEM_en}, 32'h1);
    chk("pre_rst_no_done", {31'h0, iMEM_done}, 32'h0);

    // Reset mid-miss abandons the request and invalidates the cache
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst2_en", {31'h0, oMEM_en}, 32'h0);
    chk("rst2_addr", oMEM_addr, 32'h0);
    chk("rst2_valid", {31'h0, oINST_valid}, 32'h0);
    expect_miss(32'h0);
    expect_miss(32'h4);
    expect_miss(32'h8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
